// File: rtl/data_memory_mp_if.sv
// Request/response bundle shared by all requestors of data_memory_mp.
// Every field is a flat vector with port p at slice p.
interface data_memory_mp_if #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_W = DATA_WIDTH / 8;

    logic [NUM_PORTS-1:0]            req_i;
    logic [NUM_PORTS-1:0]            gnt_o;
    logic [NUM_PORTS-1:0]            rvalid_o;
    logic [NUM_PORTS-1:0]            err_o;
    logic [NUM_PORTS-1:0]            we_i;
    logic [NUM_PORTS*BE_W-1:0]       be_i;
    logic [NUM_PORTS*32-1:0]         addr_i;
    logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i;
    logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, err_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, err_o, rdata_o
    );
endinterface

// File: rtl/data_memory_mp.sv
// Multi-port byte-writable data RAM with a round-robin arbiter and a pipelined response path.
// DATA_MEM_BOUNDS_CHECK_EN enables out-of-range error responses; without SYNTHESIS, dbg_ram mirrors all writes.
module data_memory_mp #(
    parameter int unsigned MEM_SIZE     = 4096,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_PORTS    = 2,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    data_memory_mp_if.slave bus
);
    localparam int unsigned BE_W   = DATA_WIDTH / 8;
    localparam int unsigned OFF    = $clog2(BE_W);
    localparam int unsigned WORDS  = MEM_SIZE / BE_W;
    localparam int unsigned ADDR_W = $clog2(WORDS);
    localparam int unsigned DBG_W  = $clog2(MEM_SIZE);
    localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned PIPE_D = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;

    logic [DATA_WIDTH-1:0] mem_q [WORDS];

    logic [PORT_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0]  gnt_c;
    logic [PORT_W-1:0]     win_c;
    logic                  any_c;
    int unsigned           arb_idx;

    logic [BE_W-1:0]       be_a    [NUM_PORTS];
    logic [31:0]           addr_a  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wdata_a [NUM_PORTS];

    logic                  g_we;
    logic [BE_W-1:0]       g_be;
    logic [31:0]           g_addr;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic [ADDR_W-1:0]     g_word;
    logic                  g_oob;
    logic [DATA_WIDTH-1:0] g_rdata;
    logic                  unused_addr_bits;

    logic                  tail_vld;
    logic [PORT_W-1:0]     tail_port;
    logic                  tail_err;
    logic [DATA_WIDTH-1:0] tail_data;

    logic [NUM_PORTS-1:0]  rvalid_q;
    logic [NUM_PORTS-1:0]  err_q;
    logic [DATA_WIDTH-1:0] rdata_q [NUM_PORTS];

    // Unpack the flat per-port bus fields
    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            be_a[p]    = bus.be_i[p*BE_W +: BE_W];
            addr_a[p]  = bus.addr_i[p*32 +: 32];
            wdata_a[p] = bus.wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin arbiter: first requester at or after rr_ptr_q wins
    always_comb begin
        gnt_c    = '0;
        win_c    = '0;
        any_c    = 1'b0;
        arb_idx  = 0;
        rr_ptr_d = rr_ptr_q;
        if (en_i && !rst_i) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                arb_idx = 32'(rr_ptr_q) + i;
                if (arb_idx >= NUM_PORTS) arb_idx = arb_idx - NUM_PORTS;
                if (!any_c && bus.req_i[PORT_W'(arb_idx)]) begin
                    any_c = 1'b1;
                    win_c = PORT_W'(arb_idx);
                end
            end
        end
        if (any_c) begin
            gnt_c[win_c] = 1'b1;
            if (32'(win_c) == NUM_PORTS - 1) rr_ptr_d = '0;
            else                            rr_ptr_d = win_c + PORT_W'(1);
        end
    end

    // Granted access fields and read-first data
    always_comb begin
        g_we    = bus.we_i[win_c];
        g_be    = be_a[win_c];
        g_addr  = addr_a[win_c];
        g_wdata = wdata_a[win_c];
        g_word  = g_addr[OFF +: ADDR_W];
`ifdef DATA_MEM_BOUNDS_CHECK_EN
        g_oob   = (g_addr >= 32'(MEM_SIZE));
`else
        g_oob   = 1'b0;
`endif
        g_rdata = g_oob ? '0 : mem_q[g_word];
    end

    assign unused_addr_bits = ^g_addr;

    always_ff @(posedge clk_i) begin
        if (rst_i) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end

    // RAM array is not reset
    always_ff @(posedge clk_i) begin
        if (any_c && g_we && !g_oob) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (g_be[b]) mem_q[g_word][b*8 +: 8] <= g_wdata[b*8 +: 8];
            end
        end
    end

`ifndef SYNTHESIS
    logic [7:0] dbg_ram [MEM_SIZE];

    always_ff @(posedge clk_i) begin
        if (any_c && g_we && !g_oob) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (g_be[b]) dbg_ram[DBG_W'(32'(g_word) * BE_W + b)] <= g_wdata[b*8 +: 8];
            end
        end
    end
`endif

    // Latency pipe ahead of the per-port output registers
    if (READ_LATENCY > 1) begin : g_pipe
        logic [PIPE_D-1:0]     pipe_vld_q;
        logic [PIPE_D-1:0]     pipe_err_q;
        logic [PORT_W-1:0]     pipe_port_q [PIPE_D];
        logic [DATA_WIDTH-1:0] pipe_data_q [PIPE_D];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                pipe_vld_q <= '0;
            end else begin
                pipe_vld_q[0] <= any_c;
                for (int unsigned k = 1; k < PIPE_D; k++) pipe_vld_q[k] <= pipe_vld_q[k-1];
            end
            pipe_err_q[0]  <= g_oob;
            pipe_port_q[0] <= win_c;
            pipe_data_q[0] <= g_rdata;
            for (int unsigned k = 1; k < PIPE_D; k++) begin
                pipe_err_q[k]  <= pipe_err_q[k-1];
                pipe_port_q[k] <= pipe_port_q[k-1];
                pipe_data_q[k] <= pipe_data_q[k-1];
            end
        end

        assign tail_vld  = pipe_vld_q[PIPE_D-1];
        assign tail_err  = pipe_err_q[PIPE_D-1];
        assign tail_port = pipe_port_q[PIPE_D-1];
        assign tail_data = pipe_data_q[PIPE_D-1];
    end else begin : g_nopipe
        assign tail_vld  = any_c;
        assign tail_err  = g_oob;
        assign tail_port = win_c;
        assign tail_data = g_rdata;
    end

    // Per-port response registers; rdata/err hold between responses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= '0;
            err_q    <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) rdata_q[p] <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                rvalid_q[p] <= tail_vld && (tail_port == PORT_W'(p));
                if (tail_vld && (tail_port == PORT_W'(p))) begin
                    err_q[p]   <= tail_err;
                    rdata_q[p] <= tail_data;
                end
            end
        end
    end

    always_comb begin
        bus.rdata_o = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) bus.rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = rdata_q[p];
    end

    assign bus.gnt_o    = gnt_c;
    assign bus.rvalid_o = rvalid_q;
    assign bus.err_o    = err_q;
endmodule
